// File: rtl/relay_mode_ctrl.sv
// relay_mode_ctrl
//   Relay framing controller for the hi-simulate relay path. Watches decoded
//   symbols from the demodulator, finds frame start/end for fake-reader and
//   fake-tag relaying, drives the front-end mod_type mux and re-serialises
//   received symbols onto data_out.
//
// Ports
//   clk                   system clock
//   rst_n                 asynchronous active-low reset
//   data_in               decoded symbol (SYM_W bits)
//   data_in_available     one-cycle strobe, data_in valid
//   hi_simulate_mod_type  major mode: 101 fake reader, 110 fake tag, else idle
//   mod_type              000 idle, 001 tag listen, 010 tag mod,
//                         011 reader listen, 100 reader mod
//   data_out              serialised relay bit (serialiser MSB)
//   frame_active          high while in a MOD state
//   frame_count           completed frames, wraps 255 -> 0
//   timeout_pulse         one-cycle pulse when a timeout forces listen
module relay_mode_ctrl #(
  parameter int               SYM_W      = 4,
  parameter int               HIST       = 5,
  parameter int               ALIGN      = 2,
  parameter int               DIV_LOG2   = 4,
  parameter logic [SYM_W-1:0] READER_SOF = 4'hc,
  parameter logic [SYM_W-1:0] TAG_SOF    = 4'hf,
  parameter int               TIMEOUT    = 1024
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [SYM_W-1:0] data_in,
  input  logic             data_in_available,
  input  logic [2:0]       hi_simulate_mod_type,
  output logic [2:0]       mod_type,
  output logic             data_out,
  output logic             frame_active,
  output logic [7:0]       frame_count,
  output logic             timeout_pulse
);

  typedef enum logic [2:0] {
    MT_IDLE          = 3'b000,
    MT_TAGSIM_LISTEN = 3'b001,
    MT_TAGSIM_MOD    = 3'b010,
    MT_READER_LISTEN = 3'b011,
    MT_READER_MOD    = 3'b100
  } mode_t;

  localparam logic [2:0] HS_FAKE_READER = 3'b101;
  localparam logic [2:0] HS_FAKE_TAG    = 3'b110;

  localparam int HW    = HIST * SYM_W;
  localparam int CNT_W = (ALIGN > 1) ? $clog2(ALIGN) : 1;
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [DIV_LOG2-1:0] TICK_AT   = DIV_LOG2'(1 << (DIV_LOG2 - 1));
  localparam logic [CNT_W-1:0]    SYM_LAST  = CNT_W'(ALIGN - 1);
  localparam logic [TO_W-1:0]     TMO_LAST  = TO_W'(TIMEOUT - 1);

  mode_t               state_q, state_d;
  logic [HW-1:0]       hist_q, hist_d;
  logic [SYM_W-1:0]    ser_q, ser_d;
  logic [DIV_LOG2-1:0] div_q, div_d;
  logic [CNT_W-1:0]    sym_cnt_q, sym_cnt_d;
  logic [TO_W-1:0]     tmo_q, tmo_d;
  logic [7:0]          frame_count_q, frame_count_d;
  logic                frame_active_q;
  logic                timeout_pulse_q, timeout_pulse_d;

  logic [HW-1:0]       hist_shift;
  logic [CNT_W-1:0]    sym_inc;
  logic                is_reader, is_tag;
  logic                sof_hit, eof_hit;
  logic [SYM_W-1:0]    eof_oldest;
  mode_t               listen_st, mod_st;

  // Detection always looks at the history as it will be after this strobe,
  // so a frame boundary is acted on in the same cycle the symbol arrives.
  assign hist_shift = {hist_q[HW-SYM_W-1:0], data_in};
  assign sym_inc    = (sym_cnt_q == SYM_LAST) ? '0 : sym_cnt_q + 1'b1;
  assign is_reader  = (hi_simulate_mod_type == HS_FAKE_READER);
  assign is_tag     = (hi_simulate_mod_type == HS_FAKE_TAG);
  assign listen_st  = is_reader ? MT_READER_LISTEN : MT_TAGSIM_LISTEN;
  assign mod_st     = is_reader ? MT_READER_MOD : MT_TAGSIM_MOD;
  assign eof_oldest = hist_shift[4*SYM_W-1 -: SYM_W];

  always_comb begin
    sof_hit = (hist_shift[HW-1:SYM_W] == '0) &&
              (hist_shift[SYM_W-1:0] == (is_reader ? READER_SOF : TAG_SOF));
    if (is_reader) begin
      // A reader frame may end on silence or on a repeated SOF followed by silence.
      eof_hit = (hist_shift[3*SYM_W-1:0] == '0) &&
                ((eof_oldest == '0) || (eof_oldest == READER_SOF));
    end else begin
      eof_hit = (hist_shift[2*SYM_W-1:0] == '0);
    end
  end

  always_comb begin
    state_d         = state_q;
    hist_d          = hist_q;
    ser_d           = ser_q;
    div_d           = div_q;
    sym_cnt_d       = sym_cnt_q;
    tmo_d           = tmo_q;
    frame_count_d   = frame_count_q;
    timeout_pulse_d = 1'b0;

    if (!is_reader && !is_tag) begin
      state_d   = MT_IDLE;
      hist_d    = '0;
      ser_d     = '0;
      div_d     = '0;
      sym_cnt_d = '0;
      tmo_d     = '0;
    end else begin
      div_d = div_q + 1'b1;

      // A symbol load wins over a coincident shift tick.
      if (data_in_available) begin
        hist_d    = hist_shift;
        ser_d     = data_in;
        sym_cnt_d = sym_inc;
        tmo_d     = '0;
      end else if (div_q == TICK_AT) begin
        ser_d = ser_q << 1;
      end

      if ((state_q != listen_st) && (state_q != mod_st)) begin
        // Entering (or switching) a relay mode abandons any frame in flight.
        state_d   = listen_st;
        sym_cnt_d = '0;
        tmo_d     = '0;
      end else if (state_q == listen_st) begin
        tmo_d = '0;
        if (data_in_available && sof_hit) begin
          state_d   = mod_st;
          sym_cnt_d = '0;
        end
      end else if (data_in_available) begin
        if ((sym_inc == '0) && eof_hit) begin
          state_d       = listen_st;
          frame_count_d = frame_count_q + 8'd1;
        end
      end else if (tmo_q == TMO_LAST) begin
        state_d         = listen_st;
        tmo_d           = '0;
        timeout_pulse_d = 1'b1;
      end else begin
        tmo_d = tmo_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q         <= MT_IDLE;
      hist_q          <= '0;
      ser_q           <= '0;
      div_q           <= '0;
      sym_cnt_q       <= '0;
      tmo_q           <= '0;
      frame_count_q   <= '0;
      frame_active_q  <= 1'b0;
      timeout_pulse_q <= 1'b0;
    end else begin
      state_q         <= state_d;
      hist_q          <= hist_d;
      ser_q           <= ser_d;
      div_q           <= div_d;
      sym_cnt_q       <= sym_cnt_d;
      tmo_q           <= tmo_d;
      frame_count_q   <= frame_count_d;
      frame_active_q  <= (state_d == MT_TAGSIM_MOD) || (state_d == MT_READER_MOD);
      timeout_pulse_q <= timeout_pulse_d;
    end
  end

  assign mod_type      = state_q;
  assign data_out      = ser_q[SYM_W-1];
  assign frame_active  = frame_active_q;
  assign frame_count   = frame_count_q;
  assign timeout_pulse = timeout_pulse_q;

endmodule

// File: tb/tb_relay_mode_ctrl.sv
// tb_relay_mode_ctrl
//   Directed bench for relay_mode_ctrl with default parameters. Inputs are
//   driven on the falling edge and outputs are sampled on the falling edge.
module tb_relay_mode_ctrl;

  localparam int TIMEOUT = 1024;

  logic       clk;
  logic       rst_n;
  logic [3:0] data_in;
  logic       data_in_available;
  logic [2:0] hi_simulate_mod_type;
  logic [2:0] mod_type;
  logic       data_out;
  logic       frame_active;
  logic [7:0] frame_count;
  logic       timeout_pulse;

  int compared;
  int mismatched;

  relay_mode_ctrl dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .data_in              (data_in),
    .data_in_available    (data_in_available),
    .hi_simulate_mod_type (hi_simulate_mod_type),
    .mod_type             (mod_type),
    .data_out             (data_out),
    .frame_active         (frame_active),
    .frame_count          (frame_count),
    .timeout_pulse        (timeout_pulse)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // One strobe spanning exactly one rising edge; returns on the falling edge after it.
  task automatic strobe(input logic [3:0] sym);
    @(negedge clk);
    data_in           = sym;
    data_in_available = 1'b1;
    @(negedge clk);
    data_in_available = 1'b0;
    data_in           = 4'h0;
  endtask

  // Idle for one edge so history, serialiser and divider are cleared.
  task automatic go_idle();
    @(negedge clk);
    hi_simulate_mod_type = 3'b000;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst_n                = 1'b0;
    data_in              = 4'h0;
    data_in_available    = 1'b0;
    hi_simulate_mod_type = 3'b000;
    repeat (3) @(negedge clk);
    compared++; if (mod_type !== 3'b000) begin mismatched++; $display("[TB] FAIL reset_mod_type got %0h expected 0", mod_type); end
    compared++; if (data_out !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_data_out got %0b expected 0", data_out); end
    compared++; if (frame_active !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_frame_active got %0b expected 0", frame_active); end
    compared++; if (frame_count !== 8'd0) begin mismatched++; $display("[TB] FAIL reset_frame_count got %0d expected 0", frame_count); end
    compared++; if (timeout_pulse !== 1'b0) begin mismatched++; $display("[TB] FAIL reset_timeout_pulse got %0b expected 0", timeout_pulse); end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reader_frame();
    logic [3:0] syms [11] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hc, 4'h2, 4'h6, 4'h0, 4'h0, 4'h0, 4'h0};
    logic [2:0] exp  [11] = '{3'd3, 3'd3, 3'd3, 3'd3, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd4, 3'd3};
    go_idle();
    hi_simulate_mod_type = 3'b101;
    @(negedge clk);
    compared++; if (mod_type !== 3'b011) begin mismatched++; $display("[TB] FAIL reader_listen_entry got %0h expected 3", mod_type); end
    for (int i = 0; i < 11; i++) begin
      strobe(syms[i]);
      compared++; if (mod_type !== exp[i]) begin mismatched++; $display("[TB] FAIL reader_frame_step%0d got %0h expected %0h", i, mod_type, exp[i]); end
      compared++; if (frame_active !== (exp[i] == 3'd4)) begin mismatched++; $display("[TB] FAIL reader_frame_active_step%0d got %0b expected %0b", i, frame_active, exp[i] == 3'd4); end
    end
    compared++; if (frame_count !== 8'd1) begin mismatched++; $display("[TB] FAIL reader_frame_count got %0d expected 1", frame_count); end
  endtask

  task automatic test_misaligned_end();
    logic [3:0] syms [9] = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hf, 4'h3, 4'h0, 4'h0, 4'h0};
    logic [2:0] exp  [9] = '{3'd1, 3'd1, 3'd1, 3'd1, 3'd2, 3'd2, 3'd2, 3'd2, 3'd1};
    go_idle();
    hi_simulate_mod_type = 3'b110;
    @(negedge clk);
    compared++; if (mod_type !== 3'b001) begin mismatched++; $display("[TB] FAIL tag_listen_entry got %0h expected 1", mod_type); end
    for (int i = 0; i < 9; i++) begin
      strobe(syms[i]);
      compared++; if (mod_type !== exp[i]) begin mismatched++; $display("[TB] FAIL tag_frame_step%0d got %0h expected %0h", i, mod_type, exp[i]); end
    end
    compared++; if (frame_count !== 8'd2) begin mismatched++; $display("[TB] FAIL tag_frame_count got %0d expected 2", frame_count); end
  endtask

  task automatic test_timeout();
    go_idle();
    hi_simulate_mod_type = 3'b101;
    @(negedge clk);
    strobe(4'hc);
    compared++; if (mod_type !== 3'b100) begin mismatched++; $display("[TB] FAIL timeout_enter_mod got %0h expected 4", mod_type); end
    repeat (TIMEOUT - 1) @(negedge clk);
    compared++; if (mod_type !== 3'b100) begin mismatched++; $display("[TB] FAIL timeout_early got %0h expected 4", mod_type); end
    compared++; if (timeout_pulse !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_pulse_early got %0b expected 0", timeout_pulse); end
    @(negedge clk);
    compared++; if (mod_type !== 3'b011) begin mismatched++; $display("[TB] FAIL timeout_return got %0h expected 3", mod_type); end
    compared++; if (timeout_pulse !== 1'b1) begin mismatched++; $display("[TB] FAIL timeout_pulse got %0b expected 1", timeout_pulse); end
    compared++; if (frame_active !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_frame_active got %0b expected 0", frame_active); end
    @(negedge clk);
    compared++; if (timeout_pulse !== 1'b0) begin mismatched++; $display("[TB] FAIL timeout_pulse_width got %0b expected 0", timeout_pulse); end
    compared++; if (frame_count !== 8'd2) begin mismatched++; $display("[TB] FAIL timeout_frame_count got %0d expected 2", frame_count); end
  endtask

  task automatic test_serialiser();
    logic exp [4] = '{1'b0, 1'b1, 1'b0, 1'b0};
    go_idle();
    // Divider sits at 0 here; it reaches the tick value 8 after eight active edges.
    hi_simulate_mod_type = 3'b101;
    repeat (8) @(negedge clk);
    data_in           = 4'b1010;
    data_in_available = 1'b1;
    @(negedge clk);
    data_in_available = 1'b0;
    data_in           = 4'h0;
    compared++; if (data_out !== 1'b1) begin mismatched++; $display("[TB] FAIL ser_load got %0b expected 1", data_out); end
    repeat (15) @(negedge clk);
    compared++; if (data_out !== 1'b1) begin mismatched++; $display("[TB] FAIL ser_hold got %0b expected 1", data_out); end
    @(negedge clk);
    compared++; if (data_out !== exp[0]) begin mismatched++; $display("[TB] FAIL ser_shift1 got %0b expected %0b", data_out, exp[0]); end
    for (int i = 1; i < 4; i++) begin
      repeat (16) @(negedge clk);
      compared++; if (data_out !== exp[i]) begin mismatched++; $display("[TB] FAIL ser_shift%0d got %0b expected %0b", i + 1, data_out, exp[i]); end
    end
    compared++; if (mod_type !== 3'b011) begin mismatched++; $display("[TB] FAIL ser_mod_type got %0h expected 3", mod_type); end
  endtask

  task automatic test_mode_switch();
    go_idle();
    hi_simulate_mod_type = 3'b101;
    @(negedge clk);
    strobe(4'hc);
    compared++; if (mod_type !== 3'b100) begin mismatched++; $display("[TB] FAIL switch_enter_mod got %0h expected 4", mod_type); end
    hi_simulate_mod_type = 3'b110;
    @(negedge clk);
    compared++; if (mod_type !== 3'b001) begin mismatched++; $display("[TB] FAIL switch_to_tag got %0h expected 1", mod_type); end
    compared++; if (frame_active !== 1'b0) begin mismatched++; $display("[TB] FAIL switch_frame_active got %0b expected 0", frame_active); end
    compared++; if (frame_count !== 8'd2) begin mismatched++; $display("[TB] FAIL switch_frame_count got %0d expected 2", frame_count); end
    hi_simulate_mod_type = 3'b000;
    @(negedge clk);
    compared++; if (mod_type !== 3'b000) begin mismatched++; $display("[TB] FAIL switch_to_idle got %0h expected 0", mod_type); end
    compared++; if (frame_count !== 8'd2) begin mismatched++; $display("[TB] FAIL idle_frame_count got %0d expected 2", frame_count); end
  endtask

  task automatic test_reset_mid_frame();
    go_idle();
    hi_simulate_mod_type = 3'b101;
    @(negedge clk);
    strobe(4'hc);
    compared++; if (mod_type !== 3'b100) begin mismatched++; $display("[TB] FAIL midreset_enter_mod got %0h expected 4", mod_type); end
    #2 rst_n = 1'b0;
    #1;
    compared++; if (mod_type !== 3'b000) begin mismatched++; $display("[TB] FAIL midreset_mod_type got %0h expected 0", mod_type); end
    compared++; if (frame_active !== 1'b0) begin mismatched++; $display("[TB] FAIL midreset_frame_active got %0b expected 0", frame_active); end
    compared++; if (frame_count !== 8'd0) begin mismatched++; $display("[TB] FAIL midreset_frame_count got %0d expected 0", frame_count); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    compared   = 0;
    mismatched = 0;
    test_reset();
    test_reader_frame();
    test_misaligned_end();
    test_timeout();
    test_serialiser();
    test_mode_switch();
    test_reset_mid_frame();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/relay_mode_ctrl.md
Name: relay_mode_ctrl

Overview:
- Parametrised relay framing controller for the hi-simulate relay path.
- Watches decoded symbols from the demodulator and finds frame start and frame end for fake-reader and fake-tag relaying.
- Drives mod_type for the front-end mux and re-serialises received symbols onto data_out.
- Adds over the previous generation: configurable symbol width and history depth, configurable start-of-frame symbols, a listen-return timeout, a frame counter, and defined reset and mode-change behaviour.

Parameters:
- SYM_W, 4, bits per decoded symbol.
- HIST, 5, symbols of history held for pattern matching (minimum 4).
- ALIGN, 2, symbols per byte; end-of-frame is only accepted on a byte boundary.
- DIV_LOG2, 4, serial bit period is 2^DIV_LOG2 clk cycles.
- READER_SOF, 4'hc, first symbol of a reader frame.
- TAG_SOF, 4'hf, first symbol of a tag frame.
- TIMEOUT, 1024, clk cycles without data_in_available in a MOD state before forced return to listen.

Ports:
- clk  input  1  system clock.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  SYM_W  decoded symbol.
- data_in_available  input  1  one-cycle strobe, data_in valid.
- hi_simulate_mod_type  input  3  major mode; 101 = FAKE_READER, 110 = FAKE_TAG, anything else = idle.
- mod_type  output  3  front-end mode; 000 idle, 001 TAGSIM_LISTEN, 010 TAGSIM_MOD, 011 READER_LISTEN, 100 READER_MOD.
- data_out  output  1  serialised relay bit, MSB of the serialiser.
- frame_active  output  1  high while in a MOD state.
- frame_count  output  8  completed frames, wraps 255 -> 0.
- timeout_pulse  output  1  one-cycle pulse when a timeout forces listen.

Behaviour:
- Reset (rst_n low, asynchronous) clears all registers:
  - mod_type = 000, data_out = 0, frame_active = 0, frame_count = 0, timeout_pulse = 0.
  - History, serialiser, divider, symbol counter and timeout counter all cleared.
- Idle mode: hi_simulate_mod_type not 101/110.
  - mod_type = 000 on the next clk; history and serialiser cleared; counters held at 0.
  - frame_count is retained.
- Listen entry: in FAKE_READER with mod_type 000 or 001/010, go to READER_LISTEN next cycle. In FAKE_TAG with mod_type 000 or 011/100, go to TAGSIM_LISTEN. An in-flight frame is abandoned and frame_count is not incremented.
- Divider: free-running DIV_LOG2-bit counter. Shift tick when the counter equals 2^(DIV_LOG2-1). On a tick the serialiser shifts left one bit, zero fill.
- On data_in_available in an active mode:
  - History shifts by SYM_W, data_in enters the low symbol.
  - Serialiser high SYM_W bits are loaded with data_in.
  - Symbol counter increments modulo ALIGN.
  - Load has priority over a same-cycle shift tick; no shift that cycle.
- Start of frame, evaluated on the updated history in the same strobe cycle:
  - LISTEN state; newest symbol = READER_SOF (reader) or TAG_SOF (tag); all older HIST-1 symbols zero.
  - Go to the MOD state, clear the symbol counter to 0, clear the timeout counter.
  - Start takes priority over end detection.
- End of frame, in a MOD state with the symbol counter = 0 after increment (byte aligned):
  - Reader: the newest 4 symbols are 0,0,0,0 or READER_SOF,0,0,0 (oldest first).
  - Tag: the newest 2 symbols are 0,0.
  - Return to LISTEN; frame_count increments.
- Timeout counter runs only in MOD states and clears on every strobe. When it reaches TIMEOUT-1:
  - Return to LISTEN next cycle and pulse timeout_pulse.
  - frame_count does not increment.
- frame_active equals (mod_type is 010 or 100), registered in the same cycle as mod_type.
- Latency: mod_type updates on the clk edge after the strobe edge. data_out shows the new symbol MSB one cycle after the strobe.

Test Plan:
- Reset mid-frame: in READER_MOD, assert rst_n = 0 asynchronously -> mod_type, frame_active and frame_count read 0 immediately, before the next clk edge.
- Reader frame: mode 101, strobes 0,0,0,0,c,2,6,0,0,0,0 -> mod_type 011 -> 100 after the c strobe; back to 011 after the 4th trailing 0 (aligned); frame_count = 1.
- Misaligned end: tag mode 110, symbols 0,0,0,0,f,3,0,0 with the zeros on an odd count -> stays 010 until an aligned 0,0 pair arrives; then 001, frame_count +1.
- Timeout: enter READER_MOD, then no strobes for TIMEOUT cycles -> 011 on cycle TIMEOUT, timeout_pulse high exactly 1 cycle, frame_count unchanged.
- Serialiser: strobe data_in = 4'b1010 coincident with a shift tick -> data_out sequence 1,0,1,0,0 at 16-cycle intervals; no shift lost on load.
- Mode switch: change 101 -> 110 mid READER_MOD -> mod_type 001 next cycle, frame_count unchanged; then 000 mode -> mod_type 000.
